// File: rtl/aes_round_sequencer_if.sv
// Block request/result handshake between the cipher front-end (master) and aes_round_sequencer (slave).
interface aes_round_sequencer_if;
   logic         in_valid_i;
   logic         in_ready_o;
   logic [1:0]   in_op_i;
   logic [127:0] in_data_i;
   logic [127:0] in_key_i;
   logic         out_valid_o;
   logic         out_ready_i;
   logic [127:0] out_data_o;

   modport master (
      output in_valid_i, in_op_i, in_data_i, in_key_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_data_o
   );

   modport slave (
      input  in_valid_i, in_op_i, in_data_i, in_key_i, out_ready_i,
      output in_ready_o, out_valid_o, out_data_o
   );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 round controller: owns state/round-key registers and sequences the shared units.
// Build option AES_SEQ_CLEAR_EN adds a CLEAR cycle that wipes state and key before returning to IDLE.
//
// state  | meaning
// IDLE   | in_ready_o=1, waiting for a block request
// INIT   | initial AddRoundKey, pulse ke_clear_o, round <= 1
// ROUND  | request sub_bytes and key_expand, capture both results
// FINISH | combine shift_rows/mix_columns result with the new round key
// OUT    | hold result until out_ready_i
// ERR    | one-cycle err_o after a unit timeout
// CLEAR  | zero state/key registers (AES_SEQ_CLEAR_EN only)
module aes_round_sequencer #(
   parameter int NumRounds = 10,
   parameter int SbTimeout = 15
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   aes_round_sequencer_if.slave bus,
   output logic                 sb_en_o,
   output logic [1:0]           sb_op_o,
   output logic [127:0]         sb_data_o,
   input  logic                 sb_req_i,
   input  logic [127:0]         sb_data_i,
   output logic                 sb_ack_o,
   output logic [127:0]         sr_data_o,
   input  logic [127:0]         sr_data_i,
   input  logic [127:0]         mc_data_i,
   output logic                 ke_clear_o,
   output logic                 ke_en_o,
   output logic [3:0]           ke_round_o,
   output logic [127:0]         ke_key_o,
   input  logic                 ke_req_i,
   input  logic [127:0]         ke_key_i,
   output logic                 ke_ack_o,
   output logic                 err_o
);

   localparam int              TimerW    = $clog2(SbTimeout + 1);
   localparam logic [TimerW-1:0] TimerLoad = TimerW'(SbTimeout);
   localparam logic [3:0]      LastRound = 4'(NumRounds);
   localparam logic [1:0]      OpEnc     = 2'b01;
   localparam logic [1:0]      OpDec     = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_INIT   = 3'd1,
      S_ROUND  = 3'd2,
      S_FINISH = 3'd3,
      S_OUT    = 3'd4,
      S_ERR    = 3'd5,
      S_CLEAR  = 3'd6
   } state_e;

   state_e              fsm;
   logic [127:0]        state_q;
   logic [127:0]        key_q;
   logic [127:0]        sb_q;
   logic [127:0]        nk_q;
   logic [1:0]          op_q;
   logic [3:0]          round_q;
   logic [TimerW-1:0]   timer_q;
   logic                sb_got_q;
   logic                ke_got_q;
   logic                in_ready_q;
   logic                out_valid_q;
   logic                sb_hit;
   logic                ke_hit;
   logic                last_round;

   // A unit result is taken in the very cycle its req is seen, so the acks are not registered.
   assign sb_hit     = sb_en_o & sb_req_i;
   assign ke_hit     = ke_en_o & ke_req_i;
   assign sb_ack_o   = sb_hit;
   assign ke_ack_o   = ke_hit;
   assign last_round = (round_q == LastRound);

   assign sb_op_o         = op_q;
   assign sb_data_o       = state_q;
   assign sr_data_o       = sb_q;
   assign ke_key_o        = key_q;
   assign ke_round_o      = round_q;
   assign bus.in_ready_o  = in_ready_q;
   assign bus.out_valid_o = out_valid_q;
   assign bus.out_data_o  = state_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fsm         <= S_IDLE;
         state_q     <= '0;
         key_q       <= '0;
         sb_q        <= '0;
         nk_q        <= '0;
         op_q        <= '0;
         round_q     <= '0;
         timer_q     <= '0;
         sb_got_q    <= 1'b0;
         ke_got_q    <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         sb_en_o     <= 1'b0;
         ke_en_o     <= 1'b0;
         ke_clear_o  <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         ke_clear_o <= 1'b0;
         err_o      <= 1'b0;
         case (fsm)
            S_IDLE: begin
               if (bus.in_valid_i) begin
                  if (bus.in_op_i == OpEnc || bus.in_op_i == OpDec) begin
                     state_q    <= bus.in_data_i;
                     key_q      <= bus.in_key_i;
                     op_q       <= bus.in_op_i;
                     in_ready_q <= 1'b0;
                     ke_clear_o <= 1'b1;
                     fsm        <= S_INIT;
                  end else begin
                     err_o <= 1'b1;
                  end
               end
            end
            S_INIT: begin
               state_q  <= state_q ^ key_q;
               round_q  <= 4'd1;
               sb_en_o  <= 1'b1;
               ke_en_o  <= 1'b1;
               sb_got_q <= 1'b0;
               ke_got_q <= 1'b0;
               timer_q  <= TimerLoad;
               fsm      <= S_ROUND;
            end
            S_ROUND: begin
               if (sb_hit) begin
                  sb_q     <= sb_data_i;
                  sb_en_o  <= 1'b0;
                  sb_got_q <= 1'b1;
               end
               if (ke_hit) begin
                  nk_q     <= ke_key_i;
                  ke_en_o  <= 1'b0;
                  ke_got_q <= 1'b1;
               end
               if ((sb_got_q | sb_hit) && (ke_got_q | ke_hit)) begin
                  fsm <= S_FINISH;
               end else if (timer_q == '0) begin
                  sb_en_o <= 1'b0;
                  ke_en_o <= 1'b0;
                  err_o   <= 1'b1;
                  fsm     <= S_ERR;
               end else begin
                  timer_q <= timer_q - TimerW'(1);
               end
            end
            S_FINISH: begin
               state_q <= (last_round ? sr_data_i : mc_data_i) ^ nk_q;
               key_q   <= nk_q;
               if (last_round) begin
                  out_valid_q <= 1'b1;
                  fsm         <= S_OUT;
               end else begin
                  round_q  <= round_q + 4'd1;
                  sb_en_o  <= 1'b1;
                  ke_en_o  <= 1'b1;
                  sb_got_q <= 1'b0;
                  ke_got_q <= 1'b0;
                  timer_q  <= TimerLoad;
                  fsm      <= S_ROUND;
               end
            end
            S_OUT: begin
               if (bus.out_ready_i) begin
                  out_valid_q <= 1'b0;
`ifdef AES_SEQ_CLEAR_EN
                  fsm <= S_CLEAR;
`else
                  in_ready_q <= 1'b1;
                  fsm        <= S_IDLE;
`endif
               end
            end
            S_ERR: begin
`ifdef AES_SEQ_CLEAR_EN
               fsm <= S_CLEAR;
`else
               in_ready_q <= 1'b1;
               fsm        <= S_IDLE;
`endif
            end
`ifdef AES_SEQ_CLEAR_EN
            S_CLEAR: begin
               state_q    <= '0;
               key_q      <= '0;
               in_ready_q <= 1'b1;
               fsm        <= S_IDLE;
            end
`endif
            default: begin
               in_ready_q <= 1'b1;
               fsm        <= S_IDLE;
            end
         endcase
      end
   end

endmodule
